// File: rtl/score_display_mux.sv
// score_display_mux
//   Multiplexed driver for an active-low, common-anode bank of 7-segment digits.
//   The left half of the bank shows player 1's score in decimal and the right
//   half shows player 2's. Once either score reaches WIN_SCORE, the bank
//   latches a winner and shows a blinking winner letter (A or b) on every
//   digit until clr.
//
// Ports
//   segclk  in   display clock; all state changes on its rising edge
//   clr     in   synchronous active-high reset
//   p1, p2  in   [SCORE_W-1:0] unsigned player scores
//   seg     out  [6:0] segments, active-low, bit order {g,f,e,d,c,b,a}
//   an      out  [NUM_DIGITS-1:0] anode enables, active-low one-hot, MSB = leftmost
//   winner  out  [1:0] 00 none, 01 player 1, 10 player 2 (sticky)
module score_display_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCORE_W      = 7,
  parameter int WIN_SCORE    = 5,
  parameter int REFRESH_DIV  = 1,
  parameter int BLINK_FRAMES = 64,
  parameter int LEAD_BLANK   = 0
) (
  input  logic                  segclk,
  input  logic                  clr,
  input  logic [SCORE_W-1:0]    p1,
  input  logic [SCORE_W-1:0]    p2,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [1:0]            winner
);

  localparam int H  = NUM_DIGITS / 2;
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_B     = 7'b0000011;

  function automatic int unsigned pow10(input int e);
    int unsigned r;
    r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned MAXV = pow10(H) - 1;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = G_BLANK;
    endcase
  endfunction

  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;
  logic [SCORE_W-1:0]    r_s1, r_s2;
  logic [1:0]            r_win;
  logic [FW-1:0]         r_frm;
  logic                  r_phase;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_tick, w_last, w_half2, w_win_set, w_lead;
  logic [SCORE_W-1:0]    w_s1, w_s2, w_raw;
  int unsigned           w_val;
  int                    w_exp;
  logic [3:0]            w_dig;
  logic [6:0]            w_glyph;
  logic [NUM_DIGITS-1:0] w_an;

  assign w_tick    = (r_pre == PW'(REFRESH_DIV - 1));
  assign w_last    = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_win_set = (r_win == 2'b00) &&
                     ((32'(p1) >= 32'(WIN_SCORE)) || (32'(p2) >= 32'(WIN_SCORE)));

  // Digit 0 is drawn on the same tick that takes the snapshot, so it must
  // see the live inputs rather than the not-yet-updated snapshot registers.
  assign w_s1    = (r_idx == '0) ? p1 : r_s1;
  assign w_s2    = (r_idx == '0) ? p2 : r_s2;
  assign w_half2 = (int'(r_idx) >= H);
  assign w_raw   = w_half2 ? w_s2 : w_s1;
  assign w_val   = (32'(w_raw) > MAXV) ? MAXV : 32'(w_raw);
  // Decimal weight exponent of the current digit within its half (MSD first).
  assign w_exp   = H - 1 - (w_half2 ? int'(r_idx) - H : int'(r_idx));

  // Only the selected decimal weight is extracted; divisors are constants
  // per loop iteration. A digit is a leading zero exactly when the whole
  // value is below its decimal weight (never for the units digit).
  always_comb begin
    w_dig  = 4'd0;
    w_lead = 1'b0;
    for (int k = 0; k < H; k++) begin
      if (k == w_exp) begin
        w_dig  = 4'((w_val / pow10(k)) % 10);
        w_lead = (LEAD_BLANK != 0) && (k != 0) && (w_val < pow10(k));
      end
    end
  end

  always_comb begin
    w_glyph = G_BLANK;
    if (r_win != 2'b00) begin
      if (r_phase) w_glyph = (r_win == 2'b01) ? G_A : G_B;
    end else if (!w_lead) begin
      w_glyph = glyph(w_dig);
    end
  end

  assign w_an = ~(NUM_DIGITS'(1) << (NUM_DIGITS - 1 - int'(r_idx)));

  always_ff @(posedge segclk) begin
    if (clr) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_win   <= 2'b00;
      r_frm   <= '0;
      r_phase <= 1'b1;
      r_seg   <= G_BLANK;
      r_an    <= '1;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;

      // p1 is tested first so a simultaneous win goes to player 1.
      if (r_win == 2'b00) begin
        if (32'(p1) >= 32'(WIN_SCORE))      r_win <= 2'b01;
        else if (32'(p2) >= 32'(WIN_SCORE)) r_win <= 2'b10;
      end

      // Blink timing only runs once a winner is latched; a frame ends on
      // the tick that wraps the digit index back to 0.
      if (w_win_set) begin
        r_phase <= 1'b1;
        r_frm   <= '0;
      end else if ((r_win != 2'b00) && w_tick && w_last) begin
        if (r_frm == FW'(BLINK_FRAMES - 1)) begin
          r_frm   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frm <= r_frm + 1'b1;
        end
      end

      if (w_tick) begin
        if (r_idx == '0) begin
          r_s1 <= p1;
          r_s2 <= p2;
        end
        r_an  <= w_an;
        r_seg <= w_glyph;
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  assign seg    = r_seg;
  assign an     = r_an;
  assign winner = r_win;

endmodule

// File: doc/score_display_mux.md
Name: score_display_mux

Overview:
Parametrised successor to the two-player score display driver. Time-multiplexes an active-low common-anode 7-segment bank of NUM_DIGITS digits from segclk. The left half shows player 1's score in decimal; the right half shows player 2's score. A sticky winner state replaces the scores with a blinking winner letter until clr. Adds a refresh prescaler, multi-digit decimal conversion with saturation, per-frame score snapshotting (no tearing) and leading-zero options.

Parameters:
NUM_DIGITS, 4, total digits; even, 2..8; H = NUM_DIGITS/2 digits per player
SCORE_W, 7, width of each score input
WIN_SCORE, 5, score at or above which a player wins
REFRESH_DIV, 1, segclk cycles per digit slot (1 = advance every cycle)
BLINK_FRAMES, 64, full scan frames per blink half-period in winner state
LEAD_BLANK, 0, 1 = blank leading zeros in each half (least-significant digit always shown)

Ports:
segclk  input  1  display clock; all state on rising edge
clr  input  1  synchronous active-high reset
p1  input  SCORE_W  player 1 score, unsigned
p2  input  SCORE_W  player 2 score, unsigned
seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}
an  output  NUM_DIGITS  anode enables, active-low one-hot; MSB = leftmost digit
winner  output  2  00 none, 01 player 1, 10 player 2; sticky

Behaviour:
- One clock (segclk); reset is synchronous, active-high (clr). Sampled on segclk rising edge; overrides everything else.
- Reset values: seg=7'b1111111, an=all ones, winner=00, digit index=0, prescaler=0, frame counter=0, blink phase=on, snapshots=0.
- Prescaler counts 0..REFRESH_DIV-1; tick = terminal count. All seg/an/index updates happen only on tick cycles. With REFRESH_DIV=1, every cycle is a tick.
- Digit index i runs 0..NUM_DIGITS-1 and wraps to 0. On a tick with index i: an <= ~(1 << (NUM_DIGITS-1-i)), seg <= glyph(i), index <= i+1. Outputs are registered, so they change one cycle after the tick edge.
- Snapshot: on a tick where index==0, s1/s2 capture p1/p2 and the glyph for digit 0 uses the new values. Input changes mid-frame never affect the current frame.
- Saturation: a displayed value is min(snapshot, 10^H - 1) (H=2 gives 99). Digits 0..H-1 show s1 in decimal, MSD first; digits H..NUM_DIGITS-1 show s2.
- Conversion method is free, provided glyph(i) is registered in the cycle stated above.
- Leading zeros: shown when LEAD_BLANK=0. When LEAD_BLANK=1, a zero digit preceding the first nonzero digit of its half emits 7'b1111111; the half's least-significant digit always shows.
- Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, blank=1111111.
- Winner detection uses the raw inputs every cycle while winner==00.
  - p1>=WIN_SCORE sets 01.
  - Otherwise, p2>=WIN_SCORE sets 10.
  - Simultaneous: p1 has priority.
  - Once set, winner holds until clr; later score changes are ignored.
- Winner state:
  - All digits show A (01) or b (10). The anode scan continues unchanged.
  - Blink phase is forced to on in the cycle winner becomes nonzero, and the frame counter clears.
  - Frame counter increments on each tick where index wraps to 0. At BLINK_FRAMES it clears and blink phase toggles.
  - Phase off: seg=1111111, anodes keep scanning.
- clr mid-frame: outputs blank on the next edge; the scan restarts at digit 0 on the first tick after clr deasserts. The first tick occurs REFRESH_DIV cycles after release.

Test Plan:
- Reset: hold clr 3 cycles -> seg=1111111, an=4'b1111, winner=00; first post-release tick -> an=0111, seg=1000000 (p1=0,p2=0).
- Scan/values, N=4, DIV=1: p1=3, p2=12 -> an sequence 0111,1011,1101,1110 repeating; seg 0,3,1,2 glyphs. DIV=3 -> each an value held 3 cycles.
- Snapshot/saturation: p1 changes 3->4 while index=2 -> rest of frame shows old value, next frame shows 04. p1=120 (not winner with WIN_SCORE=127) -> 99. LEAD_BLANK=1, p2=7 -> digit 2 blank, digit 3=7.
- Winner priority: p1=5 and p2=6 in the same cycle -> winner=01, all digits A. Then p1 dropped to 0 -> still A, winner=01.
- Blink: BLINK_FRAMES=2, p2=5 -> b visible 2 frames, blank 2 frames, repeating. Anodes keep cycling. clr -> winner=00 and scores return.
- Reset mid-frame at index 2 -> next edge blank; after release, the first tick drives an=0111.
